// File: rtl/mem_pkg.sv
// Shared memory-path definitions: responder FSM states, read/write flag encoding
// and the load/store opcodes used by memory control and decode.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } mem_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [3:0] OP_LDR = 4'b1001;
  localparam logic [3:0] OP_STR = 4'b1010;

  // Wait-state counter width; WAIT_CYCLES is limited to 0..15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/data_ram_array.sv
// Word storage for the data memory: write-enable write and registered read,
// written so synthesis maps it onto block RAM. Contents are never reset.
module data_ram_array #(
  parameter int DEPTH  = 4096,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem[idx];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/data_mem_responder.sv
// RAM-side responder for LDR/STR: accepts one request, waits WAIT_CYCLES,
// accesses the word array, then strobes a registered one-cycle response.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              ram_rw_flag,
  input  logic [ADDR_W-1:0] address_add_bus,
  input  logic [DATA_W-1:0] ram_data_in,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  mem_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              rw_reg, rw_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic              rsp_err_reg, rsp_err_next;

  logic              in_range;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  assign in_range = ({1'b0, addr_reg} < DEPTH_EXT);

  data_ram_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (addr_reg[IDX_W-1:0]),
    .wdata (wdata_reg),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    addr_next      = addr_reg;
    rw_next        = rw_reg;
    wdata_next     = wdata_reg;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
    ram_we         = 1'b0;
    ram_re         = 1'b0;
    req_ready      = reset_n && (state_reg == IDLE);

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          addr_next  = address_add_bus;
          rw_next    = ram_rw_flag;
          wdata_next = ram_data_in;
          cnt_next   = WAIT_LOAD;
          state_next = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          state_next = ACCESS;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ACCESS: begin
        // A reset landing on this edge must not commit the pending write.
        ram_we     = reset_n && in_range && (rw_reg == RW_WRITE);
        ram_re     = in_range && (rw_reg == RW_READ);
        state_next = RESP;
      end
      RESP: begin
        rsp_valid_next = 1'b1;
        rsp_rdata_next = (in_range && (rw_reg == RW_READ)) ? ram_rdata : '0;
        rsp_err_next   = !in_range;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  always_ff @(posedge clk) begin
    addr_reg  <= addr_next;
    rw_reg    <= rw_next;
    wdata_reg <= wdata_next;
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (2 and 0 wait states) driven by
// per-scenario tasks; expected responses are queued at accept and checked on arrival.
module tb_data_mem_responder;
  import mem_pkg::*;

  localparam int NI = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n     [NI];
  logic        req_valid   [NI];
  logic        req_ready   [NI];
  logic        ram_rw_flag [NI];
  logic [15:0] addr        [NI];
  logic [31:0] wdata       [NI];
  logic        rsp_valid   [NI];
  logic [31:0] rsp_rdata   [NI];
  logic        rsp_err     [NI];

  data_mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(4096), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .reset_n(reset_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .ram_rw_flag(ram_rw_flag[0]), .address_add_bus(addr[0]), .ram_data_in(wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  data_mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(4096), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .reset_n(reset_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .ram_rw_flag(ram_rw_flag[1]), .address_add_bus(addr[1]), .ram_data_in(wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic [31:0] model [int];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  // Response monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    for (int i = 0; i < NI; i++) begin
      if (rsp_valid[i] === 1'b1) begin
        have = (qsize(i) > 0);
        if (have) begin
          if (i == 0) e = q0.pop_front();
          else        e = q1.pop_front();
        end
        checks++;
        if (!have) begin
          errors++;
          $display("FAIL unexpected_rsp inst=%0d cyc=%0d rdata=%h err=%b", i, cyc, rsp_rdata[i], rsp_err[i]);
        end else begin
          $display("rsp inst=%0d cyc=%0d rdata=%h err=%b (want %h/%b @%0d)",
                   i, cyc, rsp_rdata[i], rsp_err[i], e.rdata, e.err, e.due);
          checks++;
          if (rsp_rdata[i] !== e.rdata) begin
            errors++;
            $display("FAIL rsp_rdata inst=%0d got=%h exp=%h", i, rsp_rdata[i], e.rdata);
          end
          checks++;
          if (rsp_err[i] !== e.err) begin
            errors++;
            $display("FAIL rsp_err inst=%0d got=%b exp=%b", i, rsp_err[i], e.err);
          end
          checks++;
          if (cyc != e.due) begin
            errors++;
            $display("FAIL rsp_latency inst=%0d got_cyc=%0d exp_cyc=%0d", i, cyc, e.due);
          end
        end
      end
    end
  end

  task automatic send(input int i, input bit rw, input logic [15:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rdata, input bit exp_err, input bit keep,
                      input bit expect_rsp, output int stalls);
    exp_t e;
    req_valid[i]   = 1'b1;
    ram_rw_flag[i] = rw;
    addr[i]        = a;
    wdata[i]       = d;
    stalls = 0;
    while (req_ready[i] !== 1'b1 && stalls < 64) begin
      @(negedge clk);
      stalls++;
    end
    if (req_ready[i] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout inst=%0d req_ready=%b exp=1", i, req_ready[i]);
    end
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.due   = cyc + wc(i) + 3;
    if (expect_rsp) begin
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      req_valid[i]   = 1'b0;
      ram_rw_flag[i] = 1'($urandom);
      addr[i]        = 16'($urandom);
      wdata[i]       = $urandom;
    end
  endtask

  task automatic drain(input int i);
    int k;
    k = 0;
    while (qsize(i) > 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (qsize(i) > 0) begin
      errors++;
      $display("FAIL rsp_timeout inst=%0d pending=%0d exp=0", i, qsize(i));
      if (i == 0) q0.delete();
      else        q1.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      reset_n[i] = 1'b0;
      req_valid[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (req_ready[i] !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_reset inst=%0d got=%b exp=0", i, req_ready[i]);
      end
      reset_n[i] = 1'b1;
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (req_ready[i] !== 1'b1) begin
        errors++;
        $display("FAIL ready_after_reset inst=%0d got=%b exp=1", i, req_ready[i]);
      end
      checks++;
      if (rsp_valid[i] !== 1'b0) begin
        errors++;
        $display("FAIL valid_after_reset inst=%0d got=%b exp=0", i, rsp_valid[i]);
      end
      checks++;
      if (rsp_rdata[i] !== 32'h0 || rsp_err[i] !== 1'b0) begin
        errors++;
        $display("FAIL rsp_after_reset inst=%0d rdata=%h err=%b exp=0/0", i, rsp_rdata[i], rsp_err[i]);
      end
    end
    $display("reset released");
  endtask

  task automatic test_write_read();
    int s;
    send(0, RW_WRITE, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b1, s);
    drain(0);
    send(0, RW_READ, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, s);
    drain(0);
    @(negedge clk);
    checks++;
    if (rsp_rdata[0] !== 32'hDEADBEEF || rsp_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL rsp_hold got=%h/%b exp=deadbeef/0", rsp_rdata[0], rsp_valid[0]);
    end
  endtask

  task automatic test_back_to_back(input int i, input logic [15:0] a, input logic [31:0] d);
    int s;
    send(i, RW_WRITE, a, d, 32'h0, 1'b0, 1'b1, 1'b1, s);
    send(i, RW_READ, a, 32'h0, d, 1'b0, 1'b0, 1'b1, s);
    checks++;
    if (s != wc(i) + 3) begin
      errors++;
      $display("FAIL b2b_stall inst=%0d got=%0d exp=%0d", i, s, wc(i) + 3);
    end
    drain(i);
  endtask

  task automatic test_out_of_range();
    int s;
    send(0, RW_WRITE, 16'h0000, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 1'b1, s);
    send(0, RW_WRITE, 16'h0FFF, 32'h0F0F0F0F, 32'h0, 1'b0, 1'b0, 1'b1, s);
    send(0, RW_WRITE, 16'h1000, 32'h12345678, 32'h0, 1'b1, 1'b0, 1'b1, s);
    send(0, RW_READ,  16'h1000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, s);
    send(0, RW_READ,  16'hFFFF, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, s);
    send(0, RW_READ,  16'h0000, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, s);
    send(0, RW_READ,  16'h0FFF, 32'h0, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b1, s);
    drain(0);
  endtask

  task automatic test_reset_mid_write();
    int  s;
    bit  seen;
    send(0, RW_WRITE, 16'h0020, 32'h11111111, 32'h0, 1'b0, 1'b0, 1'b1, s);
    drain(0);
    send(0, RW_WRITE, 16'h0020, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 1'b0, s);
    @(negedge clk);
    reset_n[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset_n[0] = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[0] !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abandoned_rsp got=1 exp=0");
    end
    send(0, RW_READ, 16'h0020, 32'h0, 32'h11111111, 1'b0, 1'b0, 1'b1, s);
    drain(0);
  endtask

  task automatic test_zero_wait();
    int s;
    send(1, RW_WRITE, 16'h0003, 32'h00000042, 32'h0, 1'b0, 1'b0, 1'b1, s);
    drain(1);
    send(1, RW_READ, 16'h0003, 32'h0, 32'h00000042, 1'b0, 1'b0, 1'b1, s);
    drain(1);
    test_back_to_back(1, 16'h0004, 32'h5A5A0004);
  endtask

  task automatic test_random();
    int          s;
    int          a;
    logic [31:0] d;
    for (int n = 0; n < 12; n++) begin
      a = 32'h100 + int'($urandom_range(7, 0));
      if (model.exists(a) && ($urandom_range(1, 0) == 1)) begin
        send(0, RW_READ, 16'(a), 32'h0, model[a], 1'b0, 1'b0, 1'b1, s);
      end else begin
        d = $urandom;
        model[a] = d;
        send(0, RW_WRITE, 16'(a), d, 32'h0, 1'b0, 1'b0, 1'b1, s);
      end
      drain(0);
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      reset_n[i]     = 1'b0;
      req_valid[i]   = 1'b0;
      ram_rw_flag[i] = 1'b0;
      addr[i]        = 16'h0;
      wdata[i]       = 32'h0;
    end
    test_reset();
    test_write_read();
    test_back_to_back(0, 16'h0011, 32'h0BADCAFE);
    test_out_of_range();
    test_reset_mid_write();
    test_zero_wait();
    test_random();
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
